sram_controller: RTL and testbench

Bridges the memory stage's single-cycle 32-bit load/store requests to an external asynchronous 16-bit SRAM. Each 32-bit word is moved as two 16-bit halves under a fixed-latency FSM. While a transfer is in flight, `ready` is deasserted so the pipeline top freezes its IF/ID/EX/MEM registers.

---
 rtl/sram_controller.sv | 149 ++++++++++++++
 tb/tb_sram_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// sram_controller: moves 32-bit load/store words to an external asynchronous
// 16-bit SRAM as two half-word accesses. A fixed-latency FSM (IDLE, LO, HI,
// DONE) holds `ready` low while a transfer is in flight so the pipeline
// freezes its stage registers.
module sram_controller #(
  parameter int          HALF_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int            CW   = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          wr_q;

  logic          req;
  logic          last;
  logic [31:0]   offset;
  logic          dq_oe;
  logic [15:0]   dq_out;
  logic          unused_bits;

  assign req  = wr_en | rd_en;
  assign last = (cnt == LAST);

  // Full 32-bit subtract so out-of-window addresses wrap modulo 2^17 words.
  assign offset      = addr_q - BASE_ADDR;
  assign unused_bits = ^{offset[31:19], offset[1:0]};

  // Chip, output and byte enables are permanently asserted.
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

  // State and phase counter registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state and phase-counter logic; the counter clears on every transition.
  // NOTE: defaults first so no path through the case leaves a variable
  // unassigned, which would infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    case (state)
      S_IDLE: if (req) state_nx = S_LO;
      S_LO: begin
        if (last) state_nx = S_HI;
        else      cnt_nx   = cnt + CW'(1);
      end
      S_HI: begin
        if (last) state_nx = S_DONE;
        else      cnt_nx   = cnt + CW'(1);
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Latch the request when it is accepted in IDLE; write wins when both are set.
  // NOTE: these are plain registers, not a memory array, so they take the
  // async reset like any other state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (state == S_IDLE && req) begin
      addr_q  <= address;
      wdata_q <= wdata;
      wr_q    <= wr_en;
    end
  end

  // Capture read halves on the last cycle of each phase; reset discards partial data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (!wr_q && last) begin
      if (state == S_LO) rdata[15:0]  <= SRAM_DQ;
      if (state == S_HI) rdata[31:16] <= SRAM_DQ;
    end
  end

  // Bus outputs and pipeline handshake, decoded from the current state.
  always_comb begin
    ready     = 1'b0;
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    case (state)
      S_IDLE: ready = ~req;
      S_LO: begin
        SRAM_ADDR = {offset[18:2], 1'b0};
        SRAM_WE_N = ~wr_q;
        dq_oe     = wr_q;
        dq_out    = wdata_q[15:0];
      end
      S_HI: begin
        SRAM_ADDR = {offset[18:2], 1'b1};
        SRAM_WE_N = ~wr_q;
        dq_oe     = wr_q;
        dq_out    = wdata_q[31:16];
      end
      S_DONE:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed and randomized loads/stores against an
// SRAM model, with a word-level reference memory predicting bus and data values.
module tb_sram_controller;

  localparam int          H    = 2;
  localparam logic [31:0] BASE = 32'd1024;
  localparam logic [15:0] IDLE_BUS = 16'hFFFF;  // pulled-up, undriven bus

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;

  int vectors     = 0;
  int miscompares = 0;

  // SRAM device model and the bench's expectation of it.
  logic [15:0] mem [0:262143];
  logic [31:0] exp_words [logic [16:0]];
  logic [31:0] last_rdata;
  logic        sram_en = 1'b0;

  always #5 clk = ~clk;

  sram_controller #(.HALF_CYCLES(H), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
    .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n),
    .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n)
  );

  pullup (sram_dq);

  // SRAM drives the bus only while the bench expects a read phase.
  assign sram_dq = (sram_en && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

  // SRAM write port.
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr] <= sram_dq;
  end

  function automatic logic [15:0] pat(input logic [17:0] idx);
    return idx[15:0] ^ 16'h3C3C;
  endfunction

  function automatic logic [31:0] model_word(input logic [16:0] w);
    if (exp_words.exists(w)) return exp_words[w];
    return {pat({w, 1'b1}), pat({w, 1'b0})};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
    check({tag, "_addr"}, 32'(sram_addr), 32'd0);
    check({tag, "_dq"},   32'(sram_dq),   32'(IDLE_BUS));
    check({tag, "_tied"}, {28'd0, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
      address = $urandom; wdata = $urandom;
      #1;
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_rdata", rdata, last_rdata);
      check_quiet("idle");
    end
  endtask

  // One full transfer: request cycle, 2H phase cycles, DONE cycle.
  task automatic do_access(input logic wr, input logic rd,
                           input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] diff;
    logic [16:0] w;
    logic [31:0] exp_rd;
    logic        hi;
    logic [15:0] exp_dq;
    diff   = addr - BASE;
    w      = diff[18:2];
    exp_rd = model_word(w);

    @(negedge clk);
    wr_en = wr; rd_en = rd; address = addr; wdata = data;
    #1;
    check("req_ready", 32'(ready), 32'd0);
    check_quiet("req");

    for (int k = 1; k <= 2 * H; k++) begin
      @(negedge clk);
      address = $urandom; wdata = $urandom;
      if (!wr) sram_en = 1'b1;
      #1;
      hi = (k > H);
      if (wr) exp_dq = hi ? data[31:16] : data[15:0];
      else    exp_dq = hi ? exp_rd[31:16] : exp_rd[15:0];
      check("xfer_ready", 32'(ready), 32'd0);
      check("xfer_addr",  32'(sram_addr), 32'({w, hi}));
      check("xfer_we_n",  32'(sram_we_n), 32'(!wr));
      check("xfer_dq",    32'(sram_dq),   32'(exp_dq));
    end

    @(negedge clk);
    sram_en = 1'b0;
    #1;
    if (wr) exp_words[w] = data;
    else    last_rdata   = exp_rd;
    check("done_ready", 32'(ready), 32'd1);
    check("done_rdata", rdata, last_rdata);
    check_quiet("done");
    if (wr) begin
      check("mem_lo", 32'(mem[{w, 1'b0}]), 32'(data[15:0]));
      check("mem_hi", 32'(mem[{w, 1'b1}]), 32'(data[31:16]));
    end
  endtask

  // Watchdog: the sequence below is fixed-length, this only guards a hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  op;

    for (int i = 0; i < 262144; i++) mem[i] = pat(18'(i));
    last_rdata = 32'd0;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; wdata = '0;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_rdata", rdata, 32'd0);
    check_quiet("rst");
    @(negedge clk);
    rst = 1'b1;

    idle_cycles(10);

    // Directed cases.
    do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, 32'd1024, 32'h0);
    idle_cycles(2);
    do_access(1'b1, 1'b0, 32'd1036, 32'h12345678);
    do_access(1'b0, 1'b1, 32'd1036, 32'h0);
    do_access(1'b1, 1'b1, 32'd1028, 32'hA5A55A5A);
    idle_cycles(1);
    do_access(1'b0, 1'b1, 32'd1028, 32'h0);

    // Reset in cycle 3 of a load: partial data discarded, bus released.
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; address = 32'd1036;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      sram_en = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0; rd_en = 1'b0; sram_en = 1'b0;
    #1;
    last_rdata = 32'd0;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_rdata", rdata, 32'd0);
    check_quiet("midrst");
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(2);
    do_access(1'b0, 1'b1, 32'd1036, 32'h0);

    // Randomized traffic, mostly inside a small window, sometimes wrapping.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) a = $urandom & 32'hFFFF_FFFC;
      else                           a = BASE + 32'($urandom_range(0, 31)) * 4;
      d = $urandom;
      case (op)
        2'd0:    do_access(1'b1, 1'b0, a, d);
        2'd1:    do_access(1'b0, 1'b1, a, d);
        default: do_access(1'b1, 1'b1, a, d);
      endcase
      if ($urandom_range(0, 3) == 0) idle_cycles(1);
    end

    idle_cycles(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
